wb_port_arbiter: RTL
====================

# wb_port_arbiter

Round-robin arbiter that shares the single 64-bit register-file write port among NREQ functional-unit requesters. Each requester presents a result value and destination tag with a valid/ready handshake. The arbiter grants at most one requester per cycle and captures the winner into an output register that drives the write port. It sits between the execution units and the 64-bit register file, and handles back-pressure from the write port and pipeline flushes.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_W, 64, result width
- TAG_W, 6, destination register tag width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash: drop held output, grant nothing this cycle
- req_valid  in  NREQ  requester i has a result pending
- req_data  in  NREQ*DATA_W  result of requester i at bits [i*DATA_W +: DATA_W]
- req_tag  in  NREQ*TAG_W  tag of requester i at bits [i*TAG_W +: TAG_W]
- req_ready  out  NREQ  one-hot grant; requester i transfers when req_valid[i] && req_ready[i]
- wb_valid  out  1  write-port data held is valid
- wb_data  out  DATA_W  write data
- wb_tag  out  TAG_W  write destination tag
- wb_ready  in  1  register file consumes wb_* this cycle

## Operation
- State: output register (wb_valid, wb_data, wb_tag) and round-robin pointer ptr (clog2(NREQ) bits).
- can_accept = !wb_valid || wb_ready, gated by !flush && !rst.
- Grant logic is combinational:
  - Search req_valid starting at index ptr, ascending, wrapping from NREQ-1 to 0.
  - The first set bit wins.
  - req_ready = onehot(winner) when can_accept and any req_valid is set; otherwise all zeros.
- req_ready never depends on req_data or req_tag. It is never asserted to a requester whose req_valid is low.
- Requester rule: once req_valid is raised, req_valid, req_data and req_tag stay stable until accepted. The exception is flush, after which requesters may drop their requests.
- On accept of requester g:
  - wb_valid <= 1
  - wb_data <= req_data[g]
  - wb_tag <= req_tag[g]
  - ptr <= (g+1) mod NREQ. Wrap is required; for NREQ not a power of two, g = NREQ-1 maps to 0.
- No accept, wb_ready=1: wb_valid <= 0. wb_data and wb_tag hold their values (don't-care when invalid).
- No accept, wb_ready=0: all output state holds.
- ptr changes only on an accept.
- flush=1:
  - wb_valid <= 0 and req_ready = 0.
  - ptr holds.
  - A wb_ready in the same cycle is irrelevant.
- rst=1 (takes priority over everything, including mid-transfer):
  - wb_valid=0, wb_data=0, wb_tag=0, ptr=0.
  - req_ready=0 combinationally while rst is high.
- Simultaneous wb_ready=1 and new accept: the old value retires and the new one loads in the same edge, with no bubble.

## Timing
- Latency: accept at edge N produces wb_valid=1 with the captured data after edge N, visible in cycle N+1.
- Throughput: 1 result/cycle while wb_ready=1 and any request is pending.
- Stall: with wb_valid=1 and wb_ready=0, req_ready=0 for all requesters. Output is stable, with no loss and no duplication.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- Reset values: wb_valid=0, wb_data=0, wb_tag=0, req_ready=0, ptr=0. The first cycle after reset deasserts has ptr=0, so requester 0 has highest priority.
- Flush takes effect on the same edge. There is no valid output in the cycle after flush.

## Test plan
- Reset/idle:
  - Stimulus: hold rst 2 cycles with all req_valid=1; release with req_valid=0.
  - Required response: req_ready=0 during reset; wb_valid=0, wb_data=0, wb_tag=0 after reset.
- Round-robin wrap:
  - Stimulus: NREQ=4, all req_valid=1 continuously, wb_ready=1, req_data[i]=64'h1000+i, tag=i.
  - Required response: grants 0,1,2,3,0,1, one per cycle; wb_data sequence 1000,1001,1002,1003,1000 starting one cycle after the first grant.
- Back-pressure:
  - Stimulus: requester 2 sends data 64'hDEAD_BEEF_0000_0002, tag 5; wb_ready=0 for 3 cycles, then 1.
  - Required response: wb_valid=1 with that value stable for 4 cycles; req_ready=0 for everyone during the stall; requester 1, pending, is granted on the cycle wb_ready=1.
- Pointer skip:
  - Stimulus: ptr=1, req_valid=4'b1001.
  - Required response: requester 3 is granted (not 0); next ptr=0; requester 0 is granted next.
- Flush:
  - Stimulus: wb_valid=1, flush=1 with req_valid=4'b1111.
  - Required response: req_ready=0 that cycle; wb_valid=0 next cycle; ptr unchanged; grants resume from the old ptr after flush drops.
- Reset mid-stall:
  - Stimulus: wb_valid=1, wb_ready=0, then rst=1 for one cycle.
  - Required response: wb_valid=0, wb_data=0 and ptr=0 on the next cycle; no transfer is reported.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundle of requester-side handshakes and the register-file write port
// shared by the write-back arbiter and its environment.
interface wb_port_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 6
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic [NREQ-1:0]        req_ready;
    logic                   wb_valid;
    logic [DATA_W-1:0]      wb_data;
    logic [TAG_W-1:0]       wb_tag;
    logic                   wb_ready;

    modport slave (
        input  req_valid, req_data, req_tag, wb_ready,
        output req_ready, wb_valid, wb_data, wb_tag
    );

    modport master (
        output req_valid, req_data, req_tag, wb_ready,
        input  req_ready, wb_valid, wb_data, wb_tag
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter funnelling NREQ functional-unit results into the single
// register-file write port through a one-entry output register.
module wb_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    wb_port_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]  ptr_r;
    logic              wb_valid_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [TAG_W-1:0]  wb_tag_r;

    logic              can_accept_s;
    logic              found_s;
    logic              accept_s;
    logic [PTR_W-1:0]  winner_s;
    logic [PTR_W-1:0]  ptr_next_s;
    logic [NREQ-1:0]   grant_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [TAG_W-1:0]  sel_tag_s;

    // Rotating priority search starting at ptr_r, plus winner operand mux.
    always_comb begin
        int   idx;
        logic hit;
        can_accept_s = (!wb_valid_r || bus.wb_ready) && !flush && !rst;
        found_s      = 1'b0;
        winner_s     = {PTR_W{1'b0}};
        idx          = 0;
        hit          = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx      = (int'(ptr_r) + off) % NREQ;
            hit      = bus.req_valid[idx] && !found_s;
            winner_s = hit ? PTR_W'(idx) : winner_s;
            found_s  = found_s || hit;
        end
        accept_s   = can_accept_s && found_s;
        grant_s    = accept_s ? ({{(NREQ-1){1'b0}}, 1'b1} << winner_s) : {NREQ{1'b0}};
        // Explicit modulo keeps the wrap correct when NREQ is not a power of two.
        ptr_next_s = PTR_W'((int'(winner_s) + 1) % NREQ);
        sel_data_s = bus.req_data[int'(winner_s)*DATA_W +: DATA_W];
        sel_tag_s  = bus.req_tag[int'(winner_s)*TAG_W +: TAG_W];
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_r <= 1'b0;
            wb_data_r  <= {DATA_W{1'b0}};
            wb_tag_r   <= {TAG_W{1'b0}};
            ptr_r      <= {PTR_W{1'b0}};
        end else if (flush) begin
            wb_valid_r <= 1'b0;
        end else if (accept_s) begin
            wb_valid_r <= 1'b1;
            wb_data_r  <= sel_data_s;
            wb_tag_r   <= sel_tag_s;
            ptr_r      <= ptr_next_s;
        end else if (bus.wb_ready) begin
            wb_valid_r <= 1'b0;
        end else begin
            wb_valid_r <= wb_valid_r;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.wb_valid  = wb_valid_r;
    assign bus.wb_data   = wb_data_r;
    assign bus.wb_tag    = wb_tag_r;
endmodule
